pmem_arbiter_adapter: RTL and testbench

//  Sits between the two L1 caches (instruction_cache, data_cache) and the mp4 top-level pmem port.

---
 rtl/pmem_arbiter_adapter.sv | 146 ++++++++++++++
 tb/tb_pmem_arbiter_adapter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_arbiter_adapter
//  Purpose  : Round-robin arbiter joining the icache and dcache line ports onto
//             one burst pmem port, splitting each line into 64-bit beats.
//  Revision : 1.0  initial release
// ============================================================================
module pmem_arbiter_adapter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [BEAT_W-1:0] pmem_wdata,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int BEATS      = LINE_W / BEAT_W;
   localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_IDX_W-1:0] C_LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                r_state;
   logic [BEAT_IDX_W-1:0] r_beat;
   logic                  r_last_d;
   logic                  r_owner_d;
   logic [LINE_W-1:0]     r_line;
   logic [LINE_W-1:0]     r_buf;
   logic [ADDR_W-1:0]     r_pmem_address;
   logic                  r_pmem_read;
   logic                  r_pmem_write;
   logic                  r_i_resp;
   logic                  r_d_resp;

   logic                  w_i_req;
   logic                  w_d_req;
   logic                  w_grant_d;
   logic                  w_grant_write;

   // On a tie the client that did not win last time gets the port.
   assign w_i_req       = i_read;
   assign w_d_req       = d_read | d_write;
   assign w_grant_d     = w_d_req & (~w_i_req | ~r_last_d);
   assign w_grant_write = w_grant_d & d_write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_beat         <= '0;
         r_last_d       <= 1'b0;
         r_owner_d      <= 1'b0;
         r_line         <= '0;
         r_buf          <= '0;
         r_pmem_address <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_i_resp       <= 1'b0;
         r_d_resp       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_i_req | w_d_req) begin
                  r_owner_d      <= w_grant_d;
                  r_last_d       <= w_grant_d;
                  r_pmem_address <= w_grant_d ? d_address : i_address;
                  r_beat         <= '0;
                  if (w_grant_write) begin
                     r_line       <= d_wdata;
                     r_pmem_write <= 1'b1;
                     r_state      <= ST_WR;
                  end else begin
                     r_pmem_read <= 1'b1;
                     r_state     <= ST_RD;
                  end
               end
            end

            ST_RD, ST_WR: begin
               if (pmem_resp) begin
                  if (r_state == ST_RD) begin
                     r_buf[int'(r_beat)*BEAT_W +: BEAT_W] <= pmem_rdata;
                  end
                  if (r_beat == C_LAST_BEAT) begin
                     r_beat         <= '0;
                     r_pmem_read    <= 1'b0;
                     r_pmem_write   <= 1'b0;
                     r_pmem_address <= '0;
                     r_i_resp       <= ~r_owner_d;
                     r_d_resp       <= r_owner_d;
                     r_state        <= ST_DONE;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end

            ST_DONE: begin
               r_i_resp <= 1'b0;
               r_d_resp <= 1'b0;
               r_state  <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = r_pmem_write ? r_line[int'(r_beat)*BEAT_W +: BEAT_W] : '0;

   // Both clients see the shared buffer; resp alone says whose data it is.
   assign i_rdata = r_buf;
   assign d_rdata = r_buf;
   assign i_resp  = r_i_resp;
   assign d_resp  = r_d_resp;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_arbiter_adapter
//  Purpose  : Randomized bench for pmem_arbiter_adapter with a transaction-level
//             reference model of arbitration, bursts and the fill buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmem_arbiter_adapter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [BEAT_W-1:0] pmem_wdata;
   logic [BEAT_W-1:0] pmem_rdata;
   logic              pmem_resp;

   always #5 clk = ~clk;

   pmem_arbiter_adapter #(
      .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Transaction model: one line transfer in flight, four beats, then a done cycle.
   bit           m_busy, m_done, m_owner_d, m_write, m_last_d;
   logic [31:0]  m_addr;
   logic [255:0] m_line, m_buf;
   int           m_beats;
   int           n_i_done, n_d_done;
   bit           raise_en;
   int           first_resp;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_owner_d = 0; m_write = 0; m_last_d = 0;
      m_addr = '0; m_line = '0; m_buf = '0; m_beats = 0;
   endtask

   function automatic logic [255:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_outputs();
      bit act;
      act = m_busy && !m_done;
      check_eq("pmem_read",    pmem_read,    act && !m_write);
      check_eq("pmem_write",   pmem_write,   act && m_write);
      check_eq("pmem_address", pmem_address, act ? m_addr : 32'h0);
      if (act && m_write) check_eq("pmem_wdata", pmem_wdata, m_line[m_beats*64 +: 64]);
      check_eq("i_resp",  i_resp,  m_done && !m_owner_d);
      check_eq("d_resp",  d_resp,  m_done && m_owner_d);
      check_eq("i_rdata", i_rdata, m_buf);
      check_eq("d_rdata", d_rdata, m_buf);
      if (first_resp == 0) begin
         if (d_resp)      first_resp = 2;
         else if (i_resp) first_resp = 1;
      end
   endtask

   task automatic drive();
      int op;
      if (m_done && !m_owner_d) i_read = 1'b0;
      else if (!i_read && rst && raise_en && $urandom_range(0, 3) == 0) begin
         i_read    = 1'b1;
         i_address = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
      end
      if (m_done && m_owner_d) begin
         d_read = 1'b0; d_write = 1'b0;
      end else if (!(d_read || d_write) && rst && raise_en && $urandom_range(0, 3) == 0) begin
         op        = $urandom_range(0, 2);
         d_read    = (op != 1);
         d_write   = (op != 0);
         d_address = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
         d_wdata   = rand_line();
      end
      if (pmem_read || pmem_write) pmem_resp = ($urandom_range(0, 9) < 7);
      else                         pmem_resp = ($urandom_range(0, 19) == 0);
      pmem_rdata = {$urandom, $urandom};
   endtask

   task automatic model_update();
      bit ir, dr;
      if (!rst) return;
      if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_busy) begin
         if (pmem_resp) begin
            if (!m_write) m_buf[m_beats*64 +: 64] = pmem_rdata;
            m_beats++;
            if (m_beats == 4) begin
               m_done = 1; m_beats = 0;
               if (m_owner_d) n_d_done++; else n_i_done++;
            end
         end
      end else begin
         ir = i_read;
         dr = d_read || d_write;
         if (ir || dr) begin
            m_owner_d = (ir && dr) ? !m_last_d : dr;
            m_last_d  = m_owner_d;
            m_busy    = 1;
            m_write   = m_owner_d && d_write;
            m_addr    = m_owner_d ? d_address : i_address;
            m_line    = d_wdata;
            m_beats   = 0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
      drive();
   endtask

   initial begin
      int guard;
      rst = 1'b0;
      i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
      pmem_rdata = '0; pmem_resp = 0;
      raise_en = 0; first_resp = 0; n_i_done = 0; n_d_done = 0;
      model_reset();
      #2;
      check_outputs();
      repeat (3) cycle();

      // Simultaneous fills right after reset: D must win, then I.
      rst = 1'b1;
      i_read = 1; i_address = 32'h0000_0060;
      d_read = 1; d_address = 32'h0000_1000;
      guard = 0;
      while (!(n_i_done == 1 && n_d_done == 1 && !m_done) && guard < 60) begin
         cycle();
         guard++;
      end
      check_eq("tie_timeout", guard < 60, 1'b1);
      check_eq("tie_first_is_d", first_resp, 2);

      raise_en = 1;
      repeat (4000) cycle();

      // Asynchronous reset in the middle of write beat 2.
      guard = 0;
      while (!(m_busy && !m_done && m_write && m_beats == 2) && guard < 3000) begin
         cycle();
         guard++;
      end
      check_eq("wr_beat2_found", guard < 3000, 1'b1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      i_read = 0; d_read = 0; d_write = 0;
      check_outputs();
      check_eq("rst_pmem_wdata", pmem_wdata, 64'h0);
      repeat (2) cycle();
      rst = 1'b1;
      repeat (1500) cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
